// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_pkg
//  Purpose  : Shared widths, dimensions and FSM state encoding for the 2x2
//             matrix-multiply sequencer and its multiply-accumulate datapath.
//  Contents : DATA_W / OUT_W / DIM / ACC_W / NUM_ELEM / IDX_W, state_t with
//             its ST_* encodings, and elem_idx() which maps (row, col) onto a
//             row-major element index.
//  Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DATA_W   = 8;
    localparam int OUT_W    = 17;
    localparam int DIM      = 2;
    localparam int ACC_W    = 2 * DATA_W;
    localparam int NUM_ELEM = DIM * DIM;
    localparam int IDX_W    = 2;

    // Sequencer state encoding (explicit 3-bit width)
    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MAC0 = 3'd2;
    localparam logic [2:0] ST_MAC1 = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Row-major element index of a 2x2 matrix
    function automatic logic [IDX_W-1:0] elem_idx(input logic row, input logic col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mac_unit
//  Purpose  : Combinational 8x8 unsigned multiply followed by a 17-bit add.
//  Ports    : a_i   [DATA_W-1:0] - multiplicand
//             b_i   [DATA_W-1:0] - multiplier
//             acc_i [OUT_W-1:0]  - addend (running partial sum)
//             sum_o [OUT_W-1:0]  - acc_i + a_i * b_i
//  Revision : 1.0 - initial release
// ============================================================================
module mac_unit
    import matmul_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OUT_W-1:0]  acc_i,
    output logic [OUT_W-1:0]  sum_o
);

    logic [ACC_W-1:0] w_prod;

    assign w_prod = a_i * b_i;
    // Two 16-bit products summed never exceed 17 bits, so no carry is lost.
    assign sum_o  = acc_i + OUT_W'(w_prod);

endmodule
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_sequencer
//  Purpose  : Loads two 2x2 unsigned 8-bit matrices element by element and
//             streams out C = A x B, one 17-bit element every two cycles, in
//             the order c00, c01, c10, c11.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-high reset
//             start    - begin a run (sampled in IDLE only)
//             abort    - synchronous cancel, returns to IDLE
//             a_in     - element of A, row-major
//             b_in     - element of B, row-major
//             in_valid - a_in/b_in carry a valid pair
//             in_ready - pair accepted this cycle (high throughout LOAD)
//             c_out    - result element, held between strobes
//             c_valid  - one-cycle strobe for c_out
//             busy     - high in every state except IDLE
//             done     - one-cycle pulse at the end of a completed run
//  Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  c_out,
    output logic              c_valid,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] a_q [NUM_ELEM];
    logic [DATA_W-1:0] b_q [NUM_ELEM];
    logic [IDX_W-1:0]  k_q;          // next element slot to fill in LOAD
    logic              row_q;        // output row index i
    logic              col_q;        // output column index j
    logic [ACC_W-1:0]  acc_q;
    logic [OUT_W-1:0]  c_out_q;
    logic              c_valid_q;

    // ------------------------------------------------------------------------
    // Datapath: one shared MAC. MAC0 computes A[i][0]*B[0][j] from zero;
    // MAC1 adds A[i][1]*B[1][j] onto the registered partial sum.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_mac_a;
    logic [DATA_W-1:0] w_mac_b;
    logic [OUT_W-1:0]  w_mac_acc;
    logic [OUT_W-1:0]  w_mac_sum;
    logic              w_first_term;

    assign w_first_term = (state_q == ST_MAC0);
    assign w_mac_a      = w_first_term ? a_q[elem_idx(row_q, 1'b0)]
                                       : a_q[elem_idx(row_q, 1'b1)];
    assign w_mac_b      = w_first_term ? b_q[elem_idx(1'b0, col_q)]
                                       : b_q[elem_idx(1'b1, col_q)];
    assign w_mac_acc    = w_first_term ? '0
                                       : {{(OUT_W-ACC_W){1'b0}}, acc_q};

    mac_unit u_mac (
        .a_i   (w_mac_a),
        .b_i   (w_mac_b),
        .acc_i (w_mac_acc),
        .sum_o (w_mac_sum)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic w_last_pair;
    logic w_last_result;

    assign w_last_pair   = in_valid && (k_q == IDX_W'(NUM_ELEM - 1));
    assign w_last_result = row_q && col_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)       state_d = ST_LOAD;
            ST_LOAD: if (w_last_pair) state_d = ST_MAC0;
            ST_MAC0:                  state_d = ST_MAC1;
            ST_MAC1: state_d = w_last_result ? ST_DONE : ST_MAC0;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
        // abort overrides everything, including a start seen in IDLE
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            row_q     <= 1'b0;
            col_q     <= 1'b0;
            acc_q     <= '0;
            c_out_q   <= '0;
            c_valid_q <= 1'b0;
            for (int e = 0; e < NUM_ELEM; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
            end
        end else begin
            state_q   <= state_d;
            c_valid_q <= 1'b0;
            if (abort) begin
                // Discard the run; c_out keeps its last delivered value.
                k_q   <= '0;
                row_q <= 1'b0;
                col_q <= 1'b0;
                acc_q <= '0;
                for (int e = 0; e < NUM_ELEM; e++) begin
                    a_q[e] <= '0;
                    b_q[e] <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        k_q   <= '0;
                        row_q <= 1'b0;
                        col_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (in_valid) begin
                            a_q[k_q] <= a_in;
                            b_q[k_q] <= b_in;
                            k_q      <= k_q + IDX_W'(1);
                        end
                    end
                    ST_MAC0: begin
                        acc_q <= w_mac_sum[ACC_W-1:0];
                    end
                    ST_MAC1: begin
                        c_out_q   <= w_mac_sum;
                        c_valid_q <= 1'b1;
                        // {i,j} walks 00,01,10,11 and wraps back to 00
                        {row_q, col_q} <= {row_q, col_q} + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign c_out    = c_out_q;
    assign c_valid  = c_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_sequencer
//  Purpose  : Self-checking bench for matmul_sequencer. Expected results come
//             from a plain matrix-product reference; timing expectations come
//             from the fixed latency after the last accepted pair.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  a_in = 8'd0;
    logic [7:0]  b_in = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] c_out;
    logic        c_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    matmul_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a_in     (a_in),
        .b_in     (b_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c_out    (c_out),
        .c_valid  (c_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Packing: bits [8k+7:8k] hold element k, row-major (m00, m01, m10, m11).
    function automatic logic [31:0] ref_c(input logic [31:0] av, input logic [31:0] bv,
                                          input int i, input int j);
        int sum = 0;
        for (int k = 0; k < 2; k++) begin
            int a_e = int'(av[(i*2+k)*8 +: 8]);
            int b_e = int'(bv[(k*2+j)*8 +: 8]);
            sum += a_e * b_e;
        end
        return 32'(sum);
    endfunction

    task automatic check_all_zero(input string tag);
        chk(tag, 32'(c_out), 32'd0);
        chk1(tag, c_valid, 1'b0);
        chk1(tag, done, 1'b0);
        chk1(tag, busy, 1'b0);
        chk1(tag, in_ready, 1'b0);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("load_busy", busy, 1'b1);
        chk1("load_in_ready", in_ready, 1'b1);
    endtask

    // Feeds n pairs with a random number of idle cycles (glo..ghi) before each.
    // Returns at the negedge of the cycle after the last acceptance.
    task automatic load_pairs(input logic [31:0] av, input logic [31:0] bv,
                              input int n, input int glo, input int ghi);
        for (int k = 0; k < n; k++) begin
            int g = int'($urandom_range(ghi, glo));
            repeat (g) begin
                in_valid = 1'b0;
                a_in     = 8'($urandom);
                b_in     = 8'($urandom);
                @(negedge clk);
                chk1("gap_in_ready", in_ready, 1'b1);
            end
            in_valid = 1'b1;
            a_in     = av[k*8 +: 8];
            b_in     = bv[k*8 +: 8];
            @(negedge clk);
            in_valid = 1'b0;
            if (k < n - 1) chk1("load_in_ready", in_ready, 1'b1);
        end
    endtask

    // Full run: results expected at t+3/5/7/9, done at t+9, IDLE at t+10.
    task automatic run_mm(input logic [31:0] av, input logic [31:0] bv,
                          input int glo, input int ghi, input bit start_mid);
        logic [31:0] exp_c [4];
        int          idx = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp_c[i*2+j] = ref_c(av, bv, i, j);
        start_run();
        load_pairs(av, bv, 4, glo, ghi);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            bit strobe = (cyc == 3) || (cyc == 5) || (cyc == 7) || (cyc == 9);
            chk1("c_valid", c_valid, strobe);
            chk1("done", done, (cyc == 9));
            chk1("busy", busy, (cyc <= 9));
            chk1("in_ready_off", in_ready, 1'b0);
            if (strobe) begin
                chk("c_out", 32'(c_out), exp_c[idx]);
                idx++;
            end else if (idx > 0) begin
                chk("c_out_hold", 32'(c_out), exp_c[idx-1]);
            end
            // start while computing must be ignored; stray in_valid too
            start    = start_mid && (cyc <= 2);
            in_valid = 1'($urandom);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a_mat;
        logic [31:0] b_mat;
        logic [31:0] ident;

        a_mat = {8'd4, 8'd3, 8'd2, 8'd1};
        b_mat = {8'd8, 8'd7, 8'd6, 8'd5};
        ident = {8'd1, 8'd0, 8'd0, 8'd1};

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);

        // Basic product, back-to-back pairs: 19, 22, 43, 50
        run_mm(a_mat, b_mat, 0, 0, 1'b0);

        // All 255: 130050 each, no truncation
        run_mm(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);

        // Three idle cycles before each pair
        run_mm(a_mat, b_mat, 3, 3, 1'b0);

        // start pulsed during MAC0/MAC1 is ignored
        run_mm(a_mat, b_mat, 0, 0, 1'b1);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            run_mm($urandom, $urandom, 0, 2, 1'(r % 2));
        end

        // abort after two pairs
        start_run();
        load_pairs(a_mat, b_mat, 2, 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        repeat (10) begin
            chk1("abort_c_valid", c_valid, 1'b0);
            chk1("abort_done", done, 1'b0);
            @(negedge clk);
        end

        // abort wins over a simultaneous start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk1("abort_vs_start", busy, 1'b0);

        // Run after abort: identity times B gives B
        run_mm(ident, b_mat, 0, 1, 1'b0);

        // Reset asserted during MAC1 clears outputs immediately
        start_run();
        load_pairs(a_mat, b_mat, 4, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mac1");
        @(negedge clk);
        chk1("rst_no_strobe", c_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_no_strobe2", c_valid, 1'b0);
        chk1("rst_idle", busy, 1'b0);

        // Clean run after reset
        run_mm($urandom, $urandom, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a 2x2 matrix multiply run; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-005 SHALL have port a_in, input, 8 bits: unsigned element of A, row-major.
REQ-006 SHALL have port b_in, input, 8 bits: unsigned element of B, row-major.
REQ-007 SHALL have port in_valid, input, 1 bit: a_in/b_in carry a valid element.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts an element this cycle.
REQ-009 SHALL have port c_out, output, 17 bits: unsigned result element of C = A x B.
REQ-010 SHALL have port c_valid, output, 1 bit: single-cycle strobe marking c_out valid.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse at end of a completed run.

Function
REQ-013 SHALL implement states IDLE, LOAD, MAC0, MAC1, DONE.
REQ-014 IDLE -> LOAD on start=1; start outside IDLE SHALL be ignored.
REQ-015 LOAD: in_ready=1; each cycle with in_valid=1 SHALL accept one pair (a_in -> A[k], b_in -> B[k]), k=0..3 in order a00,a01,a10,a11; idle cycles keep k unchanged.
REQ-016 Acceptance of the 4th pair SHALL move LOAD -> MAC0 with output index i,j = 0,0.
REQ-017 MAC0 SHALL register acc = A[i][0]*B[0][j] (16 bits); next state MAC1.
REQ-018 MAC1 SHALL register c_out = acc + A[i][1]*B[1][j] (zero-extended to 17 bits, no overflow possible, max 130050), set c_valid=1 for the following cycle only.
REQ-019 Result order SHALL be c00, c01, c10, c11; after c11, MAC1 -> DONE, otherwise index advances and MAC1 -> MAC0.
REQ-020 DONE SHALL hold done=1 for exactly one cycle, then -> IDLE.
REQ-021 Latency: last pair accepted at cycle t -> c_valid at t+3, t+5, t+7, t+9; done at t+9, coincident with the last c_valid.
REQ-022 c_out SHALL hold its last value between strobes; there is no output backpressure.
REQ-023 abort=1 in any state SHALL force IDLE next cycle, suppress any further c_valid/done, and discard loaded data; abort wins over simultaneous start.
REQ-024 in_valid outside LOAD SHALL be ignored; in_ready=0 outside LOAD.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, c_out=0, c_valid=0, done=0, busy=0, in_ready=0, acc=0, element storage=0, indices=0.
REQ-026 rst mid-run SHALL abandon the run; the first start after release SHALL begin a clean LOAD.

Structure
REQ-027 Package matmul_pkg SHALL hold the state enum, DATA_W=8, OUT_W=17, DIM=2.
REQ-028 Multiply-accumulate SHALL be a sub-module mac_unit (8x8 unsigned multiply plus 17-bit add, combinational); the sequencer owns all registers.

Verification
REQ-029 A=[1,2;3,4], B=[5,6;7,8] with back-to-back in_valid -> c_out 19, 22, 43, 50 at t+3/5/7/9, done at t+9.
REQ-030 All elements 255 -> four results of 130050 (17'h1FC02), no truncation.
REQ-031 Same data as REQ-029 with 3 idle cycles between each pair -> identical results; in_ready stays high throughout LOAD.
REQ-032 abort after 2 pairs accepted -> IDLE next cycle, no c_valid/done; a following run of A=I, B=[5,6;7,8] -> 5, 6, 7, 8.
REQ-033 start pulsed during MAC0/MAC1 -> ignored; rst asserted in MAC1 -> all outputs 0 immediately, no c_valid that cycle or next.
